// File: rtl/branch_predictor_pkg.sv
// Shared pipeline definitions: branch counter encodings, default PC width, small helpers.
package branch_predictor_pkg;

    localparam int PCW_DEF = 32;

    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } ctr_t;

    // Event counters stick at all-ones instead of wrapping back to zero.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Predictor-facing pipeline signals: ID-stage lookup, MEM-stage resolve, statistics.
interface branch_predictor_if
    import branch_predictor_pkg::*;
#(
    parameter int PCW = PCW_DEF
);
    logic [PCW-1:0] pc_ID;
    logic           br_ID;
    logic           BP_ID;
    logic [PCW-1:0] pc_BP;
    logic           br_MEM;
    logic [PCW-1:0] pc_MEM;
    logic           act_taken_MEM;
    logic [PCW-1:0] act_target_MEM;
    logic           bp_MEM;
    logic [PCW-1:0] bp_target_MEM;
    logic           taken_MEM;
    logic [PCW-1:0] next_pc;
    logic [15:0]    br_cnt;
    logic [15:0]    miss_cnt;

    modport master (
        output pc_ID, br_ID, br_MEM, pc_MEM, act_taken_MEM, act_target_MEM,
               bp_MEM, bp_target_MEM,
        input  BP_ID, pc_BP, taken_MEM, next_pc, br_cnt, miss_cnt
    );

    modport slave (
        input  pc_ID, br_ID, br_MEM, pc_MEM, act_taken_MEM, act_target_MEM,
               bp_MEM, bp_target_MEM,
        output BP_ID, pc_BP, taken_MEM, next_pc, br_cnt, miss_cnt
    );
endinterface

// File: rtl/branch_predictor_sat_counter2.sv
// 2-bit saturating taken/not-taken counter update, purely combinational.
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  ctr_t cur,
    input  logic taken,
    output ctr_t nxt
);
    // NOTE: nxt gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        nxt = cur;
        unique case (cur)
            SNT: nxt = taken ? WNT : SNT;
            WNT: nxt = taken ? WT  : SNT;
            WT:  nxt = taken ? ST  : WNT;
            ST:  nxt = taken ? ST  : WT;
            default: nxt = cur;
        endcase
    end
endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch target predictor: zero-latency ID lookup, MEM-stage
// misprediction detection and table update, saturating statistics counters.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int PCW     = PCW_DEF
)(
    input  logic               clk,
    input  logic               rst,
    branch_predictor_if.slave  bus
);
    localparam int IDXW = $clog2(ENTRIES);
    localparam int TAGW = PCW - IDXW;

    logic            valid_q  [ENTRIES];
    logic [TAGW-1:0] tag_q    [ENTRIES];
    logic [PCW-1:0]  target_q [ENTRIES];
    ctr_t            ctr_q    [ENTRIES];
    logic [15:0]     br_cnt_q;
    logic [15:0]     miss_cnt_q;

    logic [IDXW-1:0] id_idx;
    logic [TAGW-1:0] id_tag;
    logic            id_hit;
    logic            predict;

    logic [IDXW-1:0] upd_idx;
    logic [TAGW-1:0] upd_tag;
    logic            upd_hit;
    ctr_t            ctr_nxt;
    logic            mispredict;

    assign id_idx  = bus.pc_ID[IDXW-1:0];
    assign id_tag  = bus.pc_ID[PCW-1:IDXW];
    assign upd_idx = bus.pc_MEM[IDXW-1:0];
    assign upd_tag = bus.pc_MEM[PCW-1:IDXW];

    // Lookup reads the registered table only, so a same-cycle update is not visible yet.
    always_comb begin
        id_hit    = bus.br_ID && valid_q[id_idx] && (tag_q[id_idx] == id_tag);
        predict   = id_hit && ctr_q[id_idx][1];
        bus.BP_ID = predict;
        bus.pc_BP = predict ? target_q[id_idx] : '0;
    end

    always_comb begin
        mispredict = bus.br_MEM &&
                     ((bus.bp_MEM != bus.act_taken_MEM) ||
                      (bus.bp_MEM && bus.act_taken_MEM &&
                       (bus.bp_target_MEM != bus.act_target_MEM)));
        bus.taken_MEM = mispredict;
        bus.next_pc   = '0;
        if (mispredict) begin
            bus.next_pc = bus.act_taken_MEM ? bus.act_target_MEM : bus.pc_MEM + PCW'(1);
        end
    end

    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    sat_counter2 u_sat_counter2 (
        .cur   (ctr_q[upd_idx]),
        .taken (bus.act_taken_MEM),
        .nxt   (ctr_nxt)
    );

    // NOTE: the whole table is cleared by reset because the valid bits must be
    // trustworthy immediately afterwards; state updates use non-blocking (<=)
    // so every read in this edge sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= WNT;
            end
            br_cnt_q   <= '0;
            miss_cnt_q <= '0;
        end else if (bus.br_MEM) begin
            if (upd_hit) begin
                ctr_q[upd_idx] <= ctr_nxt;
                if (bus.act_taken_MEM) begin
                    target_q[upd_idx] <= bus.act_target_MEM;
                end
            end else if (bus.act_taken_MEM) begin
                valid_q[upd_idx]  <= 1'b1;
                tag_q[upd_idx]    <= upd_tag;
                target_q[upd_idx] <= bus.act_target_MEM;
                ctr_q[upd_idx]    <= WT;
            end
            br_cnt_q <= sat_inc16(br_cnt_q);
            if (mispredict) begin
                miss_cnt_q <= sat_inc16(miss_cnt_q);
            end
        end
    end

    assign bus.br_cnt   = br_cnt_q;
    assign bus.miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor with hand-computed expectations.
module tb_branch_predictor;

    logic clk;
    logic rst;
    int   asserts;
    int   fails;

    branch_predictor_if #(.PCW(32)) bus ();

    branch_predictor #(.ENTRIES(16), .PCW(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle's worth of inputs at the falling edge and let them settle.
    task automatic drive(input logic br_id, input logic [31:0] pc_id,
                         input logic br_mem, input logic [31:0] pc_mem,
                         input logic act_taken, input logic [31:0] act_target,
                         input logic bp, input logic [31:0] bp_target);
        @(negedge clk);
        bus.br_ID          = br_id;
        bus.pc_ID          = pc_id;
        bus.br_MEM         = br_mem;
        bus.pc_MEM         = pc_mem;
        bus.act_taken_MEM  = act_taken;
        bus.act_target_MEM = act_target;
        bus.bp_MEM         = bp;
        bus.bp_target_MEM  = bp_target;
        #1;
    endtask

    task automatic lookup(input logic [31:0] pc);
        drive(1'b1, pc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic resolve(input logic [31:0] pc, input logic taken, input logic [31:0] target,
                           input logic bp, input logic [31:0] bp_target);
        drive(1'b0, 32'h0, 1'b1, pc, taken, target, bp, bp_target);
    endtask

    task automatic expect_bp(input string name, input logic bp_exp, input logic [31:0] tgt_exp);
        asserts++;
        if (bus.BP_ID !== bp_exp || bus.pc_BP !== tgt_exp) begin
            fails++;
            $display("FAIL %s: BP_ID=%0b pc_BP=%h, expected BP_ID=%0b pc_BP=%h",
                     name, bus.BP_ID, bus.pc_BP, bp_exp, tgt_exp);
        end
    endtask

    task automatic expect_mem(input string name, input logic tk_exp, input logic [31:0] npc_exp);
        asserts++;
        if (bus.taken_MEM !== tk_exp || bus.next_pc !== npc_exp) begin
            fails++;
            $display("FAIL %s: taken_MEM=%0b next_pc=%h, expected taken_MEM=%0b next_pc=%h",
                     name, bus.taken_MEM, bus.next_pc, tk_exp, npc_exp);
        end
    endtask

    task automatic expect_cnt(input string name, input logic [15:0] br_exp, input logic [15:0] miss_exp);
        asserts++;
        if (bus.br_cnt !== br_exp || bus.miss_cnt !== miss_exp) begin
            fails++;
            $display("FAIL %s: br_cnt=%h miss_cnt=%h, expected br_cnt=%h miss_cnt=%h",
                     name, bus.br_cnt, bus.miss_cnt, br_exp, miss_exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        lookup(32'h40);
        expect_bp("reset_lookup", 1'b0, 32'h0);
        expect_cnt("reset_counts", 16'h0, 16'h0);
        expect_mem("reset_mem", 1'b0, 32'h0);
        rst = 1'b0;
    endtask

    // Also covers same-cycle lookup/update of index 0: lookup sees the empty entry.
    task automatic test_allocate();
        drive(1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 32'h0);
        expect_mem("alloc_mispredict", 1'b1, 32'h80);
        expect_bp("alloc_same_cycle", 1'b0, 32'h0);
        lookup(32'h40);
        expect_bp("alloc_hit", 1'b1, 32'h80);
        expect_cnt("alloc_counts", 16'd1, 16'd1);
        drive(1'b0, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        expect_bp("no_branch_no_predict", 1'b0, 32'h0);
    endtask

    task automatic test_not_taken();
        drive(1'b1, 32'h40, 1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 32'h80);
        expect_mem("nt_mispredict", 1'b1, 32'h41);
        expect_bp("nt_same_cycle_old", 1'b1, 32'h80);
        lookup(32'h40);
        expect_bp("nt_ctr_1", 1'b0, 32'h0);
        resolve(32'h40, 1'b0, 32'h0, 1'b0, 32'h0);
        expect_mem("nt_correct", 1'b0, 32'h0);
        resolve(32'h40, 1'b0, 32'h0, 1'b0, 32'h0);
        resolve(32'h40, 1'b1, 32'h80, 1'b0, 32'h0);
        expect_mem("nt_hit_taken", 1'b1, 32'h80);
        lookup(32'h40);
        expect_bp("low_saturation", 1'b0, 32'h0);
        resolve(32'h40, 1'b1, 32'h80, 1'b0, 32'h0);
        lookup(32'h40);
        expect_bp("ctr_back_to_2", 1'b1, 32'h80);
        repeat (3) resolve(32'h40, 1'b1, 32'h80, 1'b1, 32'h80);
        resolve(32'h40, 1'b0, 32'h0, 1'b1, 32'h80);
        lookup(32'h40);
        expect_bp("high_saturation_3to2", 1'b1, 32'h80);
        resolve(32'h40, 1'b0, 32'h0, 1'b1, 32'h80);
        lookup(32'h40);
        expect_bp("high_saturation_2to1", 1'b0, 32'h0);
        resolve(32'h40, 1'b1, 32'h80, 1'b0, 32'h0);
    endtask

    task automatic test_target_change();
        drive(1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 32'h90, 1'b1, 32'h80);
        expect_mem("target_change_mem", 1'b1, 32'h90);
        expect_bp("target_change_old", 1'b1, 32'h80);
        lookup(32'h40);
        expect_bp("target_change_new", 1'b1, 32'h90);
        resolve(32'h40, 1'b1, 32'h90, 1'b1, 32'h90);
        expect_mem("correct_taken", 1'b0, 32'h0);
    endtask

    task automatic test_alias();
        resolve(32'h50, 1'b1, 32'hA0, 1'b0, 32'h0);
        expect_mem("alias_alloc", 1'b1, 32'hA0);
        lookup(32'h40);
        expect_bp("alias_old_miss", 1'b0, 32'h0);
        lookup(32'h50);
        expect_bp("alias_new_hit", 1'b1, 32'hA0);
        resolve(32'h60, 1'b0, 32'h0, 1'b1, 32'hA0);
        expect_mem("miss_nt_mispredict", 1'b1, 32'h61);
        lookup(32'h50);
        expect_bp("miss_nt_no_change", 1'b1, 32'hA0);
    endtask

    task automatic test_same_cycle();
        drive(1'b1, 32'h50, 1'b1, 32'h50, 1'b0, 32'h0, 1'b1, 32'hA0);
        expect_bp("same_cycle_old_entry", 1'b1, 32'hA0);
        lookup(32'h50);
        expect_bp("same_cycle_after", 1'b0, 32'h0);
    endtask

    task automatic test_next_pc_wrap();
        resolve(32'hFFFF_FFFF, 1'b0, 32'h0, 1'b1, 32'h1234);
        expect_mem("next_pc_wrap", 1'b1, 32'h0);
    endtask

    task automatic test_counter_saturation();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        for (int i = 0; i < 70000; i++) begin
            resolve(32'h300, 1'b1, 32'h310, 1'b0, 32'h0);
        end
        lookup(32'h300);
        expect_cnt("counts_saturate", 16'hFFFF, 16'hFFFF);
        expect_bp("sat_entry_hit", 1'b1, 32'h310);
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 32'h300, 1'b1, 32'h400, 1'b1, 32'h410, 1'b0, 32'h0);
        expect_bp("mid_before_reset", 1'b1, 32'h310);
        #1;
        rst = 1'b1;
        #1;
        expect_bp("mid_async_table", 1'b0, 32'h0);
        expect_cnt("mid_async_counts", 16'h0, 16'h0);
        @(posedge clk);
        #1;
        expect_cnt("mid_update_discarded_cnt", 16'h0, 16'h0);
        rst = 1'b0;
        lookup(32'h400);
        expect_bp("mid_update_discarded_tbl", 1'b0, 32'h0);
        lookup(32'h300);
        expect_bp("mid_entry_cleared", 1'b0, 32'h0);
    endtask

    initial begin
        asserts = 0;
        fails   = 0;
        rst     = 1'b0;
        test_reset();
        test_allocate();
        test_not_taken();
        test_target_change();
        test_alias();
        test_same_cycle();
        test_next_pc_wrap();
        test_counter_saturation();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
